// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_pkg
// Description : Shared types and helpers for the front-panel button controller.
// Revision    : 1.0 - initial release
// ============================================================================
package button_pkg;

    localparam int NUM_BTN_MAX = 16;
    localparam int ID_W        = $clog2(NUM_BTN_MAX);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            press;
    } btn_evt_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce_ch.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce_ch
// Description : One button channel: 2-flop synchronizer, tick-based debounce
//               counter and the accepted (debounced) level.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce_ch #(
    parameter int STABLE_TICKS = 10,
    parameter int ACTIVE_LOW   = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic state,
    output logic evt_pulse,
    output logic evt_dir
);

    localparam int                 C_CNT_W    = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(STABLE_TICKS - 1);

    logic               w_raw;
    logic               w_accept;
    logic               r_meta;
    logic               r_sync;
    logic               r_state;
    logic [C_CNT_W-1:0] r_cnt;

    assign w_raw    = (ACTIVE_LOW != 0) ? ~raw : raw;
    // The event leaves the channel on the same edge that updates the state.
    assign w_accept = tick && (r_sync != r_state) && (r_cnt == C_CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_state <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_meta <= w_raw;
            r_sync <= r_meta;
            if (tick) begin
                if (r_sync == r_state) begin
                    r_cnt <= '0;
                end else if (r_cnt == C_CNT_LAST) begin
                    r_state <= r_sync;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + C_CNT_W'(1);
                end
            end
        end
    end

    assign state     = r_state;
    assign evt_pulse = w_accept;
    assign evt_dir   = r_sync;

endmodule
`default_nettype wire

// File: rtl/button_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : button_event_ctrl
// Description : Front-panel button controller: per-button debounce, pending
//               event store and round-robin valid/ready event output.
// Revision    : 1.0 - initial release
// ============================================================================
module button_event_ctrl
    import button_pkg::*;
#(
    parameter int NUM_BTN      = 4,
    parameter int TICK_DIV     = 1000,
    parameter int STABLE_TICKS = 10,
    parameter int ACTIVE_LOW   = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_BTN-1:0]         btn_raw,
    output logic [NUM_BTN-1:0]         btn_state,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [$clog2(NUM_BTN)-1:0] evt_id,
    output logic                       evt_press,
    output logic [NUM_BTN-1:0]         evt_overrun,
    input  logic [NUM_BTN-1:0]         ovr_clr
);

    localparam int                  C_ID_W      = $clog2(NUM_BTN);
    localparam int                  C_TICK_W    = $clog2(TICK_DIV);
    localparam logic [C_TICK_W-1:0] C_TICK_LAST = C_TICK_W'(TICK_DIV - 1);

    logic [C_TICK_W-1:0] r_tick_cnt;
    logic                w_tick;
    logic [NUM_BTN-1:0]  w_pulse;
    logic [NUM_BTN-1:0]  w_dir_in;
    logic [NUM_BTN-1:0]  r_pend;
    logic [NUM_BTN-1:0]  r_dir;
    logic [NUM_BTN-1:0]  r_ovr;
    logic [C_ID_W-1:0]   r_rr_ptr;
    logic                r_valid;
    btn_evt_t            r_evt;

    logic                w_load;
    logic                w_gnt_vld;
    logic [C_ID_W-1:0]   w_gnt_idx;
    logic [NUM_BTN-1:0]  w_gnt_mask;
    int                  w_scan;

    assign w_tick = (r_tick_cnt == C_TICK_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + C_TICK_W'(1);
        end
    end

    generate
        for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
            btn_debounce_ch #(
                .STABLE_TICKS (STABLE_TICKS),
                .ACTIVE_LOW   (ACTIVE_LOW)
            ) u_ch (
                .clk       (clk),
                .rst       (rst),
                .tick      (w_tick),
                .raw       (btn_raw[i]),
                .state     (btn_state[i]),
                .evt_pulse (w_pulse[i]),
                .evt_dir   (w_dir_in[i])
            );
        end
    endgenerate

    // First pending index at or after the round-robin pointer, with wrap.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_scan    = 0;
        for (int k = 0; k < NUM_BTN; k++) begin
            w_scan = int'(r_rr_ptr) + k;
            if (w_scan >= NUM_BTN) begin
                w_scan = w_scan - NUM_BTN;
            end
            if (!w_gnt_vld && r_pend[w_scan[C_ID_W-1:0]]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_scan[C_ID_W-1:0];
            end
        end
    end

    assign w_load     = !r_valid || evt_ready;
    assign w_gnt_mask = (w_load && w_gnt_vld) ? (NUM_BTN'(1) << w_gnt_idx) : '0;

    // A fresh edge on the entry being granted re-arms it without an overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
            r_dir  <= '0;
            r_ovr  <= '0;
        end else begin
            r_pend <= (r_pend & ~w_gnt_mask) | w_pulse;
            r_dir  <= (w_pulse & w_dir_in) | (~w_pulse & r_dir);
            r_ovr  <= (r_ovr & ~ovr_clr) | (w_pulse & r_pend & ~w_gnt_mask);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_evt    <= '0;
            r_rr_ptr <= '0;
        end else if (w_load) begin
            if (w_gnt_vld) begin
                r_valid     <= 1'b1;
                r_evt.id    <= ID_W'(w_gnt_idx);
                r_evt.press <= r_dir[w_gnt_idx];
                r_rr_ptr    <= C_ID_W'(rr_next(int'(w_gnt_idx), NUM_BTN));
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign evt_valid   = r_valid;
    assign evt_id      = C_ID_W'(r_evt.id);
    assign evt_press   = r_evt.press;
    assign evt_overrun = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_button_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_event_ctrl
// Description : Randomized self-checking bench for button_event_ctrl against
//               a cycle-level behavioural model of the event rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_event_ctrl;

    localparam int NUM_BTN      = 4;
    localparam int TICK_DIV     = 4;
    localparam int STABLE_TICKS = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_state;
    logic               evt_valid;
    logic               evt_ready;
    logic [1:0]         evt_id;
    logic               evt_press;
    logic [NUM_BTN-1:0] evt_overrun;
    logic [NUM_BTN-1:0] ovr_clr;

    always #5 clk = ~clk;

    button_event_ctrl #(
        .NUM_BTN      (NUM_BTN),
        .TICK_DIV     (TICK_DIV),
        .STABLE_TICKS (STABLE_TICKS),
        .ACTIVE_LOW   (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_state   (btn_state),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_id      (evt_id),
        .evt_press   (evt_press),
        .evt_overrun (evt_overrun),
        .ovr_clr     (ovr_clr)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: debounce as "last STABLE_TICKS tick samples since the
    // previous change all disagree with the accepted level".
    bit [NUM_BTN-1:0] m_s1, m_s2, m_state, m_pend, m_dir, m_ovr;
    bit [31:0]        m_hist [NUM_BTN];
    int               m_since[NUM_BTN];
    int               m_tcnt, m_rr, m_id;
    bit               m_valid, m_press;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_state = '0; m_pend = '0; m_dir = '0; m_ovr = '0;
        m_tcnt = 0; m_rr = 0; m_id = 0; m_valid = 1'b0; m_press = 1'b0;
        for (int i = 0; i < NUM_BTN; i++) begin
            m_hist[i]  = '0;
            m_since[i] = 0;
        end
    endtask

    task automatic model_step(input bit [NUM_BTN-1:0] raw, input bit rdy, input bit [NUM_BTN-1:0] clr);
        bit               tick;
        bit               ok;
        bit [NUM_BTN-1:0] pulse;
        bit [NUM_BTN-1:0] gmask;
        int               g;
        tick  = (m_tcnt == TICK_DIV - 1);
        pulse = '0;
        gmask = '0;
        g     = -1;
        if (!m_valid || rdy) begin
            for (int k = 0; k < NUM_BTN; k++) begin
                if (g < 0 && m_pend[(m_rr + k) % NUM_BTN]) g = (m_rr + k) % NUM_BTN;
            end
            if (g >= 0) begin
                m_valid  = 1'b1;
                m_id     = g;
                m_press  = m_dir[g];
                gmask[g] = 1'b1;
                m_rr     = (g + 1) % NUM_BTN;
            end else begin
                m_valid = 1'b0;
            end
        end
        if (tick) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                m_hist[i]  = {m_hist[i][30:0], m_s2[i]};
                m_since[i] = m_since[i] + 1;
                ok = (m_since[i] >= STABLE_TICKS);
                for (int b = 0; b < STABLE_TICKS; b++) begin
                    if (m_hist[i][b] == m_state[i]) ok = 1'b0;
                end
                if (ok) begin
                    m_state[i] = ~m_state[i];
                    m_since[i] = 0;
                    pulse[i]   = 1'b1;
                end
            end
        end
        m_ovr  = (m_ovr & ~clr) | (pulse & m_pend & ~gmask);
        m_pend = (m_pend & ~gmask) | pulse;
        m_dir  = (pulse & m_state) | (~pulse & m_dir);
        m_s2   = m_s1;
        m_s1   = raw;
        m_tcnt = (m_tcnt + 1) % TICK_DIV;
    endtask

    task automatic drive(input bit [NUM_BTN-1:0] raw, input bit rdy, input bit [NUM_BTN-1:0] clr);
        btn_raw   = raw;
        evt_ready = rdy;
        ovr_clr   = clr;
        model_step(raw, rdy, clr);
    endtask

    task automatic compare_all();
        check("btn_state",   32'(btn_state),   32'(m_state));
        check("evt_valid",   32'(evt_valid),   32'(m_valid));
        check("evt_overrun", 32'(evt_overrun), 32'(m_ovr));
        check("evt_id",      32'(evt_id),      32'(m_id));
        check("evt_press",   32'(evt_press),   32'(m_press));
    endtask

    initial begin
        logic [NUM_BTN-1:0] raw_q;
        logic [NUM_BTN-1:0] clr_v;
        logic               rdy_v;
        int                 rdy_pct;

        rst       = 1'b1;
        btn_raw   = 4'hF;
        evt_ready = 1'b1;
        ovr_clr   = '0;
        model_reset();
        repeat (3) @(negedge clk);
        compare_all();
        rst = 1'b0;

        // All buttons held through reset release: four presses in id order.
        for (int c = 0; c < 40; c++) begin
            drive(4'hF, 1'b1, 4'h0);
            @(negedge clk);
            compare_all();
        end

        raw_q = 4'hF;
        for (int seg = 0; seg < 16; seg++) begin
            rdy_pct = (seg % 3 == 0) ? 0 : ((seg % 3 == 1) ? 50 : 100);
            for (int c = 0; c < 150; c++) begin
                for (int b = 0; b < NUM_BTN; b++) begin
                    if ($urandom_range(0, 11) == 0) raw_q[b] = ~raw_q[b];
                end
                rdy_v = ($urandom_range(0, 99) < rdy_pct);
                clr_v = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
                drive(raw_q, rdy_v, clr_v);
                @(negedge clk);
                compare_all();
            end
        end

        // Stall the output with activity in flight, then reset asynchronously.
        for (int c = 0; c < 30; c++) begin
            for (int b = 0; b < NUM_BTN; b++) begin
                if ($urandom_range(0, 5) == 0) raw_q[b] = ~raw_q[b];
            end
            drive(raw_q, 1'b0, 4'h0);
            @(negedge clk);
            compare_all();
        end
        btn_raw = '0;
        rst     = 1'b1;
        #1;
        check("async_rst_state",   32'(btn_state),   32'h0);
        check("async_rst_valid",   32'(evt_valid),   32'h0);
        check("async_rst_overrun", 32'(evt_overrun), 32'h0);
        check("async_rst_id",      32'(evt_id),      32'h0);
        check("async_rst_press",   32'(evt_press),   32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 60; c++) begin
            drive(4'h0, 1'b1, 4'h0);
            @(negedge clk);
            compare_all();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
